// File: rtl/dmem_req_ctrl.sv
// dmem_req_ctrl: MEM-stage sequencer for the core's single data-memory port.
// Issues LW/LBU/SW/SB over the valid/yumi handshake and holds the pipe stalled until retirement.

// Protocol checks on the request side of the MEM stage.
module dmem_req_ctrl_chk (
  input logic       clk,
  input logic       reset,
  input logic       req_valid_i,
  input logic [1:0] state
);

  // An access in flight must keep its request asserted until it retires.
  a_req_held: assert property (@(posedge clk) disable iff (reset) (state != 2'd0) |-> req_valid_i);

endmodule

module dmem_req_ctrl #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid_i,
  input  logic                    is_load_i,
  input  logic                    is_store_i,
  input  logic                    is_byte_i,
  input  logic [addr_width_p-1:0] addr_i,
  input  logic [data_width_p-1:0] store_data_i,
  output logic [data_width_p+3:0] to_mem_o,
  output logic [addr_width_p-1:0] mem_addr_o,
  input  logic [data_width_p+1:0] from_mem_i,
  output logic                    stall_o,
  output logic [data_width_p-1:0] load_data_o,
  output logic                    load_done_o,
  output logic                    misalign_o,
  output logic [1:0]              state_o
);

  typedef enum logic [1:0] {
    DMEM_IDLE      = 2'd0,
    DMEM_REQ_SENT  = 2'd1,
    DMEM_REQ_ACKED = 2'd2
  } dmem_req_state;

  typedef struct packed {
    logic [data_width_p-1:0] write_data;
    logic                    valid;
    logic                    wen;
    logic                    byte_not_word;
    logic                    yumi;
  } mem_in_s;

  typedef struct packed {
    logic [data_width_p-1:0] read_data;
    logic                    valid;
    logic                    yumi;
  } mem_out_s;

  dmem_req_state           state_r;
  dmem_req_state           state_next_s;
  logic                    st_r;
  logic                    byte_r;
  logic [addr_width_p-1:0] addr_r;
  logic [data_width_p-1:0] wdata_r;

  mem_out_s                from_mem_s;
  mem_in_s                 to_mem_s;

  logic                    idle_s;
  logic                    op_s;
  logic                    misalign_s;
  logic                    issue_s;
  logic                    cur_st_s;
  logic                    cur_byte_s;
  logic [addr_width_p-1:0] cur_addr_s;
  logic [data_width_p-1:0] cur_wdata_s;
  logic                    valid_s;
  logic                    store_done_s;
  logic                    load_done_s;
  logic                    ack_s;
  logic                    complete_s;
  logic                    stall_s;

  assign from_mem_s = from_mem_i;
  assign to_mem_o   = to_mem_s;

  // Zero-extended byte from little-endian lane (lane 0 = bits 7:0).
  function automatic logic [data_width_p-1:0] lane_extract(
    input logic [data_width_p-1:0] word,
    input logic [1:0]              lane
  );
    logic [data_width_p-1:0] res;
    res = '0;
    case (lane)
      2'd0:    res[7:0] = word[7:0];
      2'd1:    res[7:0] = word[15:8];
      2'd2:    res[7:0] = word[23:16];
      2'd3:    res[7:0] = word[31:24];
      default: res = '0;
    endcase
    return res;
  endfunction

  // Decode the current access, its completion and the next state.
  always_comb begin
    idle_s       = (state_r == DMEM_IDLE);
    op_s         = req_valid_i & (is_load_i | is_store_i);
    misalign_s   = idle_s & op_s & ~is_byte_i & (addr_i[1:0] != 2'b00);
    issue_s      = idle_s & op_s & ~misalign_s;

    // Once issued, the captured copy drives the port so a dropped request still finishes cleanly.
    if (idle_s) begin
      cur_st_s    = is_store_i;
      cur_byte_s  = is_byte_i;
      cur_addr_s  = addr_i;
      cur_wdata_s = is_byte_i ? {4{store_data_i[7:0]}} : store_data_i;
    end else begin
      cur_st_s    = st_r;
      cur_byte_s  = byte_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
    end

    valid_s      = issue_s | (state_r == DMEM_REQ_SENT);
    store_done_s = valid_s & cur_st_s & from_mem_s.yumi;
    load_done_s  = ~cur_st_s & from_mem_s.valid &
                   ((valid_s & from_mem_s.yumi) | (state_r == DMEM_REQ_ACKED));
    ack_s        = valid_s & ~cur_st_s & from_mem_s.yumi & ~from_mem_s.valid;
    complete_s   = store_done_s | load_done_s;
    stall_s      = req_valid_i & (op_s | ~idle_s) & ~complete_s & ~misalign_s;

    state_next_s = DMEM_IDLE;
    case (state_r)
      DMEM_IDLE: begin
        if (issue_s & ~complete_s) begin
          state_next_s = ack_s ? DMEM_REQ_ACKED : DMEM_REQ_SENT;
        end else begin
          state_next_s = DMEM_IDLE;
        end
      end
      DMEM_REQ_SENT: begin
        if (complete_s) begin
          state_next_s = DMEM_IDLE;
        end else if (ack_s) begin
          state_next_s = DMEM_REQ_ACKED;
        end else begin
          state_next_s = DMEM_REQ_SENT;
        end
      end
      DMEM_REQ_ACKED: begin
        if (load_done_s) begin
          state_next_s = DMEM_IDLE;
        end else begin
          state_next_s = DMEM_REQ_ACKED;
        end
      end
      default: state_next_s = DMEM_IDLE;
    endcase
  end

  // Drive the memory port and pipeline controls; everything stays at zero through reset.
  always_comb begin
    to_mem_s    = '0;
    mem_addr_o  = '0;
    stall_o     = 1'b0;
    load_data_o = '0;
    load_done_o = 1'b0;
    misalign_o  = 1'b0;
    state_o     = 2'd0;
    if (reset) begin
      to_mem_s = '0;
    end else begin
      to_mem_s.valid = valid_s;
      to_mem_s.yumi  = load_done_s;
      if (valid_s) begin
        to_mem_s.write_data    = cur_st_s ? cur_wdata_s : '0;
        to_mem_s.wen           = cur_st_s;
        to_mem_s.byte_not_word = cur_byte_s;
        mem_addr_o             = cur_addr_s;
      end else begin
        mem_addr_o = '0;
      end
      if (load_done_s) begin
        load_data_o = cur_byte_s ? lane_extract(from_mem_s.read_data, cur_addr_s[1:0])
                                 : from_mem_s.read_data;
      end else begin
        load_data_o = '0;
      end
      stall_o     = stall_s;
      load_done_o = load_done_s;
      misalign_o  = misalign_s;
      state_o     = state_r;
    end
  end

  // State register and the request fields captured at issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= DMEM_IDLE;
      st_r    <= 1'b0;
      byte_r  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (issue_s) begin
        st_r    <= cur_st_s;
        byte_r  <= cur_byte_s;
        addr_r  <= cur_addr_s;
        wdata_r <= cur_wdata_s;
      end else begin
        st_r    <= st_r;
        byte_r  <= byte_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
    end
  end

  dmem_req_ctrl_chk u_chk (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .state       (state_r)
  );

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// tb_dmem_req_ctrl: directed vector table, timed handshake sequences and a randomized run
// against a transaction-level model of the MEM-stage memory port.
module tb_dmem_req_ctrl;

  logic        clk = 1'b0;
  logic        reset, req_valid_i, is_load_i, is_store_i, is_byte_i;
  logic [31:0] addr_i, store_data_i;
  logic [35:0] to_mem_o;
  logic [31:0] mem_addr_o;
  logic [33:0] from_mem_i;
  logic        stall_o;
  logic [31:0] load_data_o;
  logic        load_done_o, misalign_o;
  logic [1:0]  state_o;
  logic        m_yumi, m_valid;
  logic [31:0] m_rdata;

  assign from_mem_i = {m_rdata, m_valid, m_yumi};

  always #5 clk = ~clk;

  dmem_req_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .is_load_i    (is_load_i),
    .is_store_i   (is_store_i),
    .is_byte_i    (is_byte_i),
    .addr_i       (addr_i),
    .store_data_i (store_data_i),
    .to_mem_o     (to_mem_o),
    .mem_addr_o   (mem_addr_o),
    .from_mem_i   (from_mem_i),
    .stall_o      (stall_o),
    .load_data_o  (load_data_o),
    .load_done_o  (load_done_o),
    .misalign_o   (misalign_o),
    .state_o      (state_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] tm(input logic [31:0] wd, input logic v, w, b, y);
    return {wd, v, w, b, y};
  endfunction

  task automatic check_outputs(input string tag, input logic [35:0] e_to, input logic [31:0] e_addr,
                               input logic e_stall, input logic [31:0] e_ldata, input logic e_done,
                               input logic e_mis, input logic [1:0] e_state);
    check($sformatf("%s to_mem", tag), to_mem_o, e_to);
    check($sformatf("%s mem_addr", tag), mem_addr_o, e_addr);
    check($sformatf("%s stall", tag), stall_o, e_stall);
    check($sformatf("%s load_data", tag), load_data_o, e_ldata);
    check($sformatf("%s load_done", tag), load_done_o, e_done);
    check($sformatf("%s misalign", tag), misalign_o, e_mis);
    check($sformatf("%s state", tag), state_o, e_state);
  endtask

  typedef struct {
    logic        rst, req, ld, st, by;
    logic [31:0] addr, sdata;
    logic        my, mv;
    logic [31:0] rdata;
    logic [35:0] e_to;
    logic [31:0] e_addr;
    logic        e_stall;
    logic [31:0] e_ldata;
    logic        e_done, e_mis;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, req, ld, st, by, input logic [31:0] addr, sdata,
                     input logic my, mv, input logic [31:0] rdata,
                     input logic [35:0] e_to, input logic [31:0] e_addr, input logic e_stall,
                     input logic [31:0] e_ldata, input logic e_done, e_mis, input logic [1:0] e_state);
    vec_t v;
    v = '{rst, req, ld, st, by, addr, sdata, my, mv, rdata,
          e_to, e_addr, e_stall, e_ldata, e_done, e_mis, e_state};
    vecs.push_back(v);
  endtask

  // One access with memory yumi after yd cycles and (loads) the data beat vd cycles later.
  task automatic timed_access(input string tag, input logic st, input logic [31:0] ad, sd, rd,
                              input int yd, vd, input logic [31:0] exp_ld);
    int last;
    last = st ? yd : yd + vd;
    for (int cyc = 0; cyc <= last; cyc++) begin
      @(negedge clk);
      reset = 1'b0; req_valid_i = 1'b1; is_load_i = !st; is_store_i = st; is_byte_i = 1'b0;
      addr_i = ad; store_data_i = sd;
      m_yumi = (cyc == yd); m_valid = !st && (cyc == last); m_rdata = rd;
      #1;
      check($sformatf("%s stall c%0d", tag, cyc), stall_o, cyc != last);
      check($sformatf("%s valid c%0d", tag, cyc), to_mem_o[3], cyc <= yd);
      check($sformatf("%s state c%0d", tag, cyc), state_o, (cyc == 0) ? 0 : ((cyc <= yd) ? 1 : 2));
      if (st) begin
        check($sformatf("%s to_mem c%0d", tag, cyc), to_mem_o, tm(sd, 1'b1, 1'b1, 1'b0, 1'b0));
      end else begin
        check($sformatf("%s load_done c%0d", tag, cyc), load_done_o, cyc == last);
        if (cyc == last) check($sformatf("%s load_data", tag), load_data_o, exp_ld);
      end
    end
    @(negedge clk);
    req_valid_i = 1'b0; m_yumi = 1'b0; m_valid = 1'b0;
    #1;
    check($sformatf("%s back_idle", tag), state_o, 0);
  endtask

  // Transaction-level reference: at most one access outstanding, tracked as pending/acked.
  logic        mp_pend = 1'b0, mp_acked = 1'b0, mp_st = 1'b0, mp_by = 1'b0;
  logic [31:0] mp_addr = 32'h0, mp_wd = 32'h0;
  logic        c_issue, c_complete, c_st, c_by;
  logic [31:0] c_addr, c_wd;
  logic [35:0] x_to;
  logic [31:0] x_addr, x_ldata;
  logic        x_stall, x_done, x_mis;
  logic [1:0]  x_state;

  task automatic model_eval();
    logic vout;
    x_to = '0; x_addr = '0; x_ldata = '0; x_stall = 1'b0; x_done = 1'b0; x_mis = 1'b0; x_state = 2'd0;
    c_issue = 1'b0; c_complete = 1'b0; c_st = 1'b0; c_by = 1'b0; c_addr = '0; c_wd = '0; vout = 1'b0;
    if (!reset) begin
      if (mp_pend) begin
        c_st = mp_st; c_by = mp_by; c_addr = mp_addr; c_wd = mp_wd;
        vout = !mp_acked;
        x_state = mp_acked ? 2'd2 : 2'd1;
      end else if (req_valid_i && (is_load_i || is_store_i)) begin
        if (!is_byte_i && addr_i[1:0] != 2'b00) begin
          x_mis = 1'b1;
        end else begin
          c_issue = 1'b1; c_st = is_store_i; c_by = is_byte_i; c_addr = addr_i;
          c_wd = is_byte_i ? {4{store_data_i[7:0]}} : store_data_i;
          vout = 1'b1;
        end
      end
      if (c_st) c_complete = vout && m_yumi;
      else c_complete = (c_issue || mp_pend) && m_valid && ((vout && m_yumi) || (mp_pend && mp_acked));
      x_done  = !c_st && c_complete;
      x_to    = {(vout && c_st) ? c_wd : 32'h0, vout, vout && c_st, vout && c_by, x_done};
      x_addr  = vout ? c_addr : 32'h0;
      x_ldata = x_done ? (c_by ? ((m_rdata >> (8 * c_addr[1:0])) & 32'hFF) : m_rdata) : 32'h0;
      x_stall = req_valid_i && (c_issue || mp_pend) && !c_complete;
    end
  endtask

  task automatic model_advance();
    if (reset) begin
      mp_pend = 1'b0;
    end else if (mp_pend) begin
      if (c_complete) mp_pend = 1'b0;
      else if (!mp_acked && !mp_st && m_yumi) mp_acked = 1'b1;
    end else if (c_issue && !c_complete) begin
      mp_pend = 1'b1; mp_acked = !c_st && m_yumi;
      mp_st = c_st; mp_by = c_by; mp_addr = c_addr; mp_wd = c_wd;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int kind;
    reset = 1'b1; req_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0; is_byte_i = 1'b0;
    addr_i = 32'h0; store_data_i = 32'h0; m_yumi = 1'b0; m_valid = 1'b0; m_rdata = 32'h0;

    // rst req ld st by addr sdata my mv rdata | to_mem addr stall ldata done mis state
    for (int i = 0; i < 3; i++)
      add(1,1,0,1,0, 32'h40, 32'hDEADBEEF, 1,0, 32'h0, 36'h0, 32'h0, 0, 32'h0, 0,0, 2'd0);
    add(0,0,0,0,0, 32'h0, 32'h0, 0,0, 32'h0, 36'h0, 32'h0, 0, 32'h0, 0,0, 2'd0);
    add(0,1,0,1,0, 32'h40, 32'hDEADBEEF, 0,0, 32'h0, tm(32'hDEADBEEF,1,1,0,0), 32'h40, 1, 32'h0, 0,0, 2'd0);
    add(0,1,0,1,0, 32'h40, 32'hDEADBEEF, 0,0, 32'h0, tm(32'hDEADBEEF,1,1,0,0), 32'h40, 1, 32'h0, 0,0, 2'd1);
    add(0,1,0,1,0, 32'h40, 32'hDEADBEEF, 1,0, 32'h0, tm(32'hDEADBEEF,1,1,0,0), 32'h40, 0, 32'h0, 0,0, 2'd1);
    add(0,0,0,0,0, 32'h0, 32'h0, 0,0, 32'h0, 36'h0, 32'h0, 0, 32'h0, 0,0, 2'd0);
    add(0,1,1,0,0, 32'h80, 32'h0, 1,0, 32'h0, tm(32'h0,1,0,0,0), 32'h80, 1, 32'h0, 0,0, 2'd0);
    add(0,1,1,0,0, 32'h80, 32'h0, 0,0, 32'h0, 36'h0, 32'h0, 1, 32'h0, 0,0, 2'd2);
    add(0,1,1,0,0, 32'h80, 32'h0, 0,1, 32'h12345678, tm(32'h0,0,0,0,1), 32'h0, 0, 32'h12345678, 1,0, 2'd2);
    add(0,0,0,0,0, 32'h0, 32'h0, 0,0, 32'h0, 36'h0, 32'h0, 0, 32'h0, 0,0, 2'd0);
    add(0,1,1,0,1, 32'h83, 32'h0, 1,1, 32'hA1B2C3D4, tm(32'h0,1,0,1,1), 32'h83, 0, 32'h000000A1, 1,0, 2'd0);
    add(0,1,0,1,1, 32'h81, 32'h000000EE, 1,0, 32'h0, tm(32'hEEEEEEEE,1,1,1,0), 32'h81, 0, 32'h0, 0,0, 2'd0);
    add(0,1,1,0,0, 32'h82, 32'h0, 1,1, 32'hFFFFFFFF, 36'h0, 32'h0, 0, 32'h0, 0,1, 2'd0);
    add(0,0,0,0,0, 32'h0, 32'h0, 0,0, 32'h0, 36'h0, 32'h0, 0, 32'h0, 0,0, 2'd0);
    add(0,1,0,0,0, 32'h44, 32'h12345678, 1,1, 32'h0, 36'h0, 32'h0, 0, 32'h0, 0,0, 2'd0);
    add(0,0,0,0,0, 32'h0, 32'h0, 0,1, 32'hFFFFFFFF, 36'h0, 32'h0, 0, 32'h0, 0,0, 2'd0);
    add(0,1,1,0,0, 32'h90, 32'h0, 1,0, 32'h0, tm(32'h0,1,0,0,0), 32'h90, 1, 32'h0, 0,0, 2'd0);
    add(0,1,1,0,0, 32'h90, 32'h0, 0,0, 32'h0, 36'h0, 32'h0, 1, 32'h0, 0,0, 2'd2);
    add(1,1,1,0,0, 32'h90, 32'h0, 0,1, 32'h55555555, 36'h0, 32'h0, 0, 32'h0, 0,0, 2'd0);
    add(0,0,0,0,0, 32'h0, 32'h0, 0,1, 32'h55555555, 36'h0, 32'h0, 0, 32'h0, 0,0, 2'd0);
    add(0,1,0,1,0, 32'h41, 32'h0BADF00D, 1,0, 32'h0, 36'h0, 32'h0, 0, 32'h0, 0,1, 2'd0);
    add(0,1,1,0,1, 32'h60, 32'h0, 0,0, 32'h0, tm(32'h0,1,0,1,0), 32'h60, 1, 32'h0, 0,0, 2'd0);
    add(0,1,1,0,1, 32'h60, 32'h0, 1,1, 32'h11223344, tm(32'h0,1,0,1,1), 32'h60, 0, 32'h00000044, 1,0, 2'd1);
    add(0,0,0,0,0, 32'h0, 32'h0, 0,0, 32'h0, 36'h0, 32'h0, 0, 32'h0, 0,0, 2'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; req_valid_i = vecs[i].req; is_load_i = vecs[i].ld;
      is_store_i = vecs[i].st; is_byte_i = vecs[i].by; addr_i = vecs[i].addr;
      store_data_i = vecs[i].sdata; m_yumi = vecs[i].my; m_valid = vecs[i].mv; m_rdata = vecs[i].rdata;
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].e_to, vecs[i].e_addr, vecs[i].e_stall,
                    vecs[i].e_ldata, vecs[i].e_done, vecs[i].e_mis, vecs[i].e_state);
    end

    timed_access("sw_slow", 1'b1, 32'h100, 32'hCAFEF00D, 32'h0, 5, 0, 32'h0);
    timed_access("lw_slow", 1'b0, 32'h200, 32'h0, 32'h0F1E2D3C, 3, 4, 32'h0F1E2D3C);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = (i < 2) || ($urandom_range(0, 59) == 0);
      if (!mp_pend) begin
        kind = $urandom_range(0, 5);
        req_valid_i = (kind != 0);
        is_load_i   = (kind == 2) || (kind == 3);
        is_store_i  = (kind == 4) || (kind == 5);
        is_byte_i   = (kind == 3) || (kind == 5);
        if (kind == 0) begin
          is_load_i = 1'($urandom_range(0, 1)); is_store_i = 1'($urandom_range(0, 1));
        end
        addr_i = $urandom;
        if (!is_byte_i && $urandom_range(0, 3) != 0) addr_i[1:0] = 2'b00;
        store_data_i = $urandom;
      end
      m_yumi = ($urandom_range(0, 2) == 0);
      m_valid = ($urandom_range(0, 2) == 0);
      m_rdata = $urandom;
      #1;
      model_eval();
      check_outputs($sformatf("rand%0d", i), x_to, x_addr, x_stall, x_ldata, x_done, x_mis, x_state);
      model_advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
